// File: rtl/bsg_source_sync_output_mc_pkg.sv
// Shared types and sizing helpers for the multi-channel source-synchronous launch stage.
// Beat layout {valid, chan, data} is common to the output register and the override vector.
package bsg_source_sync_output_mc_pkg;

    localparam int sso_channels_lp = 4;
    localparam int sso_width_lp    = 8;

    function automatic int sso_id_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int sso_credit_w(input int lg_start_credits);
        return lg_start_credits + 1;
    endfunction

    localparam int sso_id_w_lp = sso_id_w(sso_channels_lp);

    typedef struct packed {
        logic                   valid;
        logic [sso_id_w_lp-1:0] chan;
        logic [sso_width_lp-1:0] data;
    } sso_beat_t;

endpackage

// File: rtl/bsg_source_sync_output_mc_if.sv
// Core-side, token, control and io-side signals of the launch stage.
// io_parity_r_o exists only when BSG_SOURCE_SYNC_OUTPUT_MC_PARITY_EN is defined.
interface bsg_source_sync_output_mc_if
    import bsg_source_sync_output_mc_pkg::*;
#(
    parameter int channels_p = sso_channels_lp,
    parameter int width_p    = sso_width_lp
);
    localparam int id_w = sso_id_w(channels_p);

    logic [channels_p-1:0]         core_v_i;
    logic [channels_p*width_p-1:0] core_data_i;
    logic [channels_p-1:0]         core_yumi_o;
    logic [channels_p-1:0]         token_i;
    logic                          infinite_credits_i;
    logic                          override_en_i;
    logic [id_w+width_p:0]         override_valid_data_i;
    logic                          io_valid_r_o;
    logic [id_w-1:0]               io_chan_r_o;
    logic [width_p-1:0]            io_data_r_o;
    logic [channels_p-1:0]         credit_overflow_o;
`ifdef BSG_SOURCE_SYNC_OUTPUT_MC_PARITY_EN
    logic                          io_parity_r_o;
`endif

    modport master (
        input  core_v_i, core_data_i, token_i, infinite_credits_i,
        input  override_en_i, override_valid_data_i,
        output core_yumi_o, io_valid_r_o, io_chan_r_o, io_data_r_o, credit_overflow_o
`ifdef BSG_SOURCE_SYNC_OUTPUT_MC_PARITY_EN
        , output io_parity_r_o
`endif
    );

    modport slave (
        output core_v_i, core_data_i, token_i, infinite_credits_i,
        output override_en_i, override_valid_data_i,
        input  core_yumi_o, io_valid_r_o, io_chan_r_o, io_data_r_o, credit_overflow_o
`ifdef BSG_SOURCE_SYNC_OUTPUT_MC_PARITY_EN
        , input io_parity_r_o
`endif
    );

endinterface

// File: rtl/bsg_sso_credit_counter.sv
// Per-channel credit pool: +2**d per token, -1 per send, clamped at the start value.
// Latency: credits_avail_o reflects this cycle's token/send on the next cycle.
// Backpressure: credits_avail_o=0 blocks the channel; overflow_o is sticky until reset.
module bsg_sso_credit_counter
    import bsg_source_sync_output_mc_pkg::*;
#(
    parameter int lg_start_credits_p              = 5,
    parameter int lg_credit_to_token_decimation_p = 3
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic token_i,
    input  logic send_i,
    output logic credits_avail_o,
    output logic overflow_o
);
    localparam int cw = sso_credit_w(lg_start_credits_p);
    localparam logic [cw:0] start_lp = (cw+1)'(2**lg_start_credits_p);
    localparam logic [cw:0] token_lp = (cw+1)'(2**lg_credit_to_token_decimation_p);

    logic [cw-1:0] credits_q, credits_d;
    logic          overflow_q, overflow_d;
    logic [cw:0]   sum;

    // One extra bit of headroom so start + token can be seen before clamping.
    always_comb begin
        sum = {1'b0, credits_q};
        if (token_i) sum = sum + token_lp;
        if (send_i)  sum = sum - (cw+1)'(1);
        credits_d  = sum[cw-1:0];
        overflow_d = overflow_q;
        if (sum > start_lp) begin
            credits_d  = start_lp[cw-1:0];
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credits_q  <= start_lp[cw-1:0];
            overflow_q <= 1'b0;
        end else begin
            credits_q  <= credits_d;
            overflow_q <= overflow_d;
        end
    end

    assign credits_avail_o = (credits_q != '0);
    assign overflow_o      = overflow_q;

endmodule

// File: rtl/bsg_source_sync_output_mc.sv
// Round-robin merge of credit-gated channels onto one registered, channel-tagged io beat.
// Latency: 1 cycle from core_yumi_o to io_valid_r_o. Backpressure: no credits -> no yumi.
// Optional io_parity_r_o via BSG_SOURCE_SYNC_OUTPUT_MC_PARITY_EN.
module bsg_source_sync_output_mc
    import bsg_source_sync_output_mc_pkg::*;
#(
    parameter int channels_p                      = sso_channels_lp,
    parameter int width_p                         = sso_width_lp,
    parameter int lg_start_credits_p              = 5,
    parameter int lg_credit_to_token_decimation_p = 3,
    parameter logic [2*width_p-1:0] inactive_pattern_p = {width_p{2'b01}}
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    bsg_source_sync_output_mc_if.master  link
);
    localparam int id_w = sso_id_w(channels_p);
    localparam logic [id_w-1:0] last_chan_lp = id_w'(channels_p - 1);

    logic [channels_p-1:0] credits_avail, overflow, eligible, yumi, send;
    logic                  found_hi, found_lo, grant;
    logic [id_w-1:0]       win_hi, win_lo, winner, ptr_q, ptr_d;
    sso_beat_t             beat_q, beat_d;

    for (genvar i = 0; i < channels_p; i++) begin : g_ch
        bsg_sso_credit_counter #(
            .lg_start_credits_p              (lg_start_credits_p),
            .lg_credit_to_token_decimation_p (lg_credit_to_token_decimation_p)
        ) u_cnt (
            .clk_i           (clk_i),
            .reset_n_i       (reset_n_i),
            .token_i         (link.token_i[i]),
            .send_i          (send[i]),
            .credits_avail_o (credits_avail[i]),
            .overflow_o      (overflow[i])
        );
    end

    assign eligible = link.core_v_i & (credits_avail | {channels_p{link.infinite_credits_i}});

    // Lowest eligible index at/after the pointer wins; otherwise lowest below it (wrap).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int c = channels_p - 1; c >= 0; c--) begin
            if (eligible[c]) begin
                if (id_w'(c) >= ptr_q) begin
                    found_hi = 1'b1;
                    win_hi   = id_w'(c);
                end else begin
                    found_lo = 1'b1;
                    win_lo   = id_w'(c);
                end
            end
        end
        winner = found_hi ? win_hi : win_lo;
        grant  = (found_hi | found_lo) & ~link.override_en_i;
        for (int c = 0; c < channels_p; c++) begin
            yumi[c] = grant && (winner == id_w'(c));
        end
        send = yumi & ~{channels_p{link.infinite_credits_i}};
    end

    always_comb begin
        beat_d.valid = 1'b0;
        beat_d.chan  = '0;
        beat_d.data  = inactive_pattern_p[width_p-1:0];
        ptr_d        = ptr_q;
        if (link.override_en_i) begin
            beat_d = sso_beat_t'(link.override_valid_data_i);
        end else if (grant) begin
            beat_d.valid = 1'b1;
            beat_d.chan  = winner;
            beat_d.data  = link.core_data_i[winner*width_p +: width_p];
            ptr_d        = (winner == last_chan_lp) ? '0 : winner + id_w'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            beat_q <= '{valid: 1'b0, chan: '0, data: inactive_pattern_p[width_p-1:0]};
            ptr_q  <= '0;
        end else begin
            beat_q <= beat_d;
            ptr_q  <= ptr_d;
        end
    end

    assign link.core_yumi_o       = yumi;
    assign link.io_valid_r_o      = beat_q.valid;
    assign link.io_chan_r_o       = beat_q.chan;
    assign link.io_data_r_o       = beat_q.data;
    assign link.credit_overflow_o = overflow;

`ifdef BSG_SOURCE_SYNC_OUTPUT_MC_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = ^beat_d;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) parity_q <= 1'b0;
        else            parity_q <= parity_d;
    end

    assign link.io_parity_r_o = parity_q;
`endif

endmodule

// File: tb/tb_bsg_source_sync_output_mc.sv
// Bench for bsg_source_sync_output_mc: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a credit/round-robin reference model.
module tb_bsg_source_sync_output_mc;
    localparam int CH    = 4;
    localparam int W     = 8;
    localparam int START = 32;
    localparam int TOK   = 8;

    logic clk_i     = 1'b0;
    logic reset_n_i = 1'b1;
    always #5 clk_i = ~clk_i;

    bsg_source_sync_output_mc_if #(.channels_p(CH), .width_p(W)) link();

    bsg_source_sync_output_mc #(
        .channels_p                      (CH),
        .width_p                         (W),
        .lg_start_credits_p              (5),
        .lg_credit_to_token_decimation_p (3)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .link      (link)
    );

    // Reference model state
    int          cred [CH];
    int          ptr;
    logic [CH-1:0] m_ovf;
    logic        m_valid;
    logic [1:0]  m_chan;
    logic [7:0]  m_data;
    bit          chk_en = 1'b0;
    int          ycnt [CH];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) cred[c] = START;
        ptr     = 0;
        m_ovf   = '0;
        m_valid = 1'b0;
        m_chan  = 2'd0;
        m_data  = 8'h55;
    endtask

    task automatic clr_inputs();
        link.core_v_i              = '0;
        link.core_data_i           = '0;
        link.token_i               = '0;
        link.infinite_credits_i    = 1'b0;
        link.override_en_i         = 1'b0;
        link.override_valid_data_i = '0;
    endtask

    // Compare DUT against the model, then advance the model by one clock.
    task automatic model_compare();
        int win;
        logic [CH-1:0] ey;
        chk("io_valid", link.io_valid_r_o, m_valid);
        chk("io_chan", link.io_chan_r_o, m_chan);
        chk("io_data", link.io_data_r_o, m_data);
        chk("overflow", link.credit_overflow_o, m_ovf);
`ifdef BSG_SOURCE_SYNC_OUTPUT_MC_PARITY_EN
        chk("io_parity", link.io_parity_r_o, ^{m_valid, m_chan, m_data});
`endif
        win = -1;
        if (!link.override_en_i) begin
            for (int k = 0; k < CH; k++) begin
                int c = (ptr + k) % CH;
                if (win < 0 && link.core_v_i[c] && (cred[c] > 0 || link.infinite_credits_i))
                    win = c;
            end
        end
        ey = '0;
        if (win >= 0) ey[win] = 1'b1;
        chk("yumi", link.core_yumi_o, ey);

        if (link.override_en_i) begin
            {m_valid, m_chan, m_data} = link.override_valid_data_i;
        end else if (win >= 0) begin
            m_valid = 1'b1;
            m_chan  = win[1:0];
            m_data  = link.core_data_i[win*W +: W];
            ptr     = (win + 1) % CH;
            if (!link.infinite_credits_i) cred[win] = cred[win] - 1;
        end else begin
            m_valid = 1'b0;
            m_chan  = 2'd0;
            m_data  = 8'h55;
        end
        for (int c = 0; c < CH; c++) begin
            if (link.token_i[c]) begin
                cred[c] = cred[c] + TOK;
                if (cred[c] > START) begin
                    cred[c]  = START;
                    m_ovf[c] = 1'b1;
                end
            end
        end
    endtask

    // One clock: check mid-cycle, then return just after the next rising edge.
    task automatic cyc();
        @(negedge clk_i);
        if (chk_en) model_compare();
        for (int c = 0; c < CH; c++) ycnt[c] += int'(link.core_yumi_o[c]);
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr_cnt();
        for (int c = 0; c < CH; c++) ycnt[c] = 0;
    endtask

    task automatic do_reset();
        chk_en    = 1'b0;
        reset_n_i = 1'b0;
        #2;
        chk("rst_valid", link.io_valid_r_o, 0);
        chk("rst_chan", link.io_chan_r_o, 0);
        chk("rst_data", link.io_data_r_o, 8'h55);
        chk("rst_overflow", link.credit_overflow_o, 0);
`ifdef BSG_SOURCE_SYNC_OUTPUT_MC_PARITY_EN
        chk("rst_parity", link.io_parity_r_o, 0);
`endif
        clr_inputs();
        @(posedge clk_i);
        #1;
        model_reset();
        reset_n_i = 1'b1;
        chk_en    = 1'b1;
    endtask

    initial begin
        clr_inputs();
        #1;
        do_reset();

        // Single channel drains its 32 start credits, then stalls.
        clr_cnt();
        link.core_v_i = 4'b0001;
        for (int i = 0; i < 40; i++) begin
            link.core_data_i = $urandom;
            cyc();
        end
        chk("ch0_sends", ycnt[0], 32);
        chk("ch0_stall_yumi", link.core_yumi_o, 0);
        chk("idle_valid", link.io_valid_r_o, 0);
        chk("idle_data", link.io_data_r_o, 8'h55);

        // One token on an empty channel buys exactly 8 more beats.
        clr_cnt();
        link.token_i = 4'b0001;
        cyc();
        link.token_i = '0;
        for (int i = 0; i < 20; i++) begin
            link.core_data_i = $urandom;
            cyc();
        end
        chk("ch0_token_sends", ycnt[0], 8);

        // Round-robin order with all channels valid.
        do_reset();
        link.core_v_i = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            link.core_data_i = $urandom;
            cyc();
            chk("rr_valid", link.io_valid_r_o, 1);
            chk("rr_order", link.io_chan_r_o, k % 4);
        end
        link.core_v_i = '0;
        cyc();

        // ch2 at 20 credits, token and send together -> 27 credits remain.
        do_reset();
        clr_cnt();
        link.core_v_i = 4'b0100;
        for (int i = 0; i < 12; i++) begin
            link.core_data_i = $urandom;
            cyc();
        end
        chk("ch2_pre_sends", ycnt[2], 12);
        link.token_i = 4'b0100;
        cyc();
        link.token_i = '0;
        clr_cnt();
        for (int i = 0; i < 35; i++) begin
            link.core_data_i = $urandom;
            cyc();
        end
        chk("ch2_after_token", ycnt[2], 27);
        chk("ch2_stall_yumi", link.core_yumi_o, 0);

        // Token at full credits: sticky overflow, credits stay at 32.
        do_reset();
        link.token_i = 4'b0010;
        cyc();
        link.token_i = '0;
        cyc();
        chk("ovf_set", link.credit_overflow_o, 4'b0010);
        for (int i = 0; i < 5; i++) cyc();
        chk("ovf_sticky", link.credit_overflow_o, 4'b0010);
        clr_cnt();
        link.core_v_i = 4'b0010;
        for (int i = 0; i < 40; i++) begin
            link.core_data_i = $urandom;
            cyc();
        end
        chk("ch1_full_sends", ycnt[1], 32);

        // Infinite credits spend nothing.
        do_reset();
        clr_cnt();
        link.infinite_credits_i = 1'b1;
        link.core_v_i = 4'b1000;
        for (int i = 0; i < 40; i++) cyc();
        chk("inf_sends", ycnt[3], 40);
        link.infinite_credits_i = 1'b0;
        clr_cnt();
        for (int i = 0; i < 40; i++) cyc();
        chk("post_inf_sends", ycnt[3], 32);

        // Override loads the vector verbatim and blocks yumi.
        do_reset();
        link.core_v_i              = 4'b1111;
        link.override_en_i         = 1'b1;
        link.override_valid_data_i = {1'b1, 2'd3, 8'hA5};
        #1;
        chk("ovr_yumi", link.core_yumi_o, 0);
        cyc();
        chk("ovr_valid", link.io_valid_r_o, 1);
        chk("ovr_chan", link.io_chan_r_o, 3);
        chk("ovr_data", link.io_data_r_o, 8'hA5);
`ifdef BSG_SOURCE_SYNC_OUTPUT_MC_PARITY_EN
        chk("ovr_parity", link.io_parity_r_o, 1);
`endif
        link.override_en_i = 1'b0;
        cyc();
        chk("resume_valid", link.io_valid_r_o, 1);
        chk("resume_chan", link.io_chan_r_o, 0);

        // Randomized traffic with a reset in the middle.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) do_reset();
            link.core_v_i    = 4'($urandom);
            link.core_data_i = $urandom;
            for (int c = 0; c < CH; c++) link.token_i[c] = ($urandom_range(0, 47) == 0);
            link.infinite_credits_i    = ($urandom_range(0, 31) == 0);
            link.override_en_i         = ($urandom_range(0, 31) == 0);
            link.override_valid_data_i = 11'($urandom);
            cyc();
        end
        clr_inputs();
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
